// File: rtl/shift_reg_sipo_framed_rx_pkg.sv
// Shared definitions for the framed SIPO receiver: FSM encodings and a sizing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_reg_sipo_framed_rx_pkg;

    // FSM encodings. Plain constants rather than an enum so the state register
    // stays a simple vector that older tools and netlists can follow.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Ceiling log2, used to size the bit counter at elaboration time.
    // clog2(1) = 0, clog2(9) = 4, clog2(33) = 6.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_reg_sipo_framed_rx_core.sv
// Enabled shift register with a first-bit load; direction chosen by MSB_FIRST.
// Latency: sreg updates on the clock edge; sreg_nxt is the same-cycle combinational next value.
// Backpressure: none; the caller decides when load/en are asserted.
//
// Ports:
//   clk      clock, all state changes on the posedge
//   rst      synchronous active-high reset, clears the register
//   en       shift SI into the register this cycle
//   load     start a new word: register becomes SI in the first-bit position,
//            all other bits cleared; takes priority over en
//   si       serial data in
//   sreg     current register contents
//   sreg_nxt value the register takes at the next edge (used to capture a word on
//            the same edge its last bit is sampled)
module shift_reg_sipo_core #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             si,
    output logic [WIDTH-1:0] sreg,
    output logic [WIDTH-1:0] sreg_nxt
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;

    // The first bit is placed where WIDTH-1 further shifts will carry it to the
    // word's bit-0 landing position: Q[WIDTH-1] for MSB-first, Q[0] otherwise.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted   = {sreg[WIDTH-2:0], si};
            assign first_bit = {{(WIDTH-1){1'b0}}, si};
        end else begin : g_lsb_first
            assign shifted   = {si, sreg[WIDTH-1:1]};
            assign first_bit = {si, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    always_comb begin
        sreg_nxt = sreg;
        if (load) begin
            sreg_nxt = first_bit;
        end else if (en) begin
            sreg_nxt = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else begin
            sreg <= sreg_nxt;
        end
    end

endmodule

// File: rtl/shift_reg_sipo_framed_rx.sv
// Framed serial-in/parallel-out receiver: FSYNC starts a word, WIDTH bits complete it.
// Latency: zero; Q/VALID update on the same edge that samples the last serial bit.
// Backpressure: single output slot with VALID/READY; a word completing into a full,
//               non-draining slot is dropped and sets the sticky OVR flag.
//
// Ports:
//   C       clock
//   R       synchronous active-high reset, overrides every other input
//   SEN     shift enable; SI and FSYNC are only looked at when SEN=1
//   SI      serial data in
//   FSYNC   SI sampled this cycle is bit 0 of a new word
//   Q       received word (registered, stable while VALID=1 and READY=0)
//   VALID   Q holds an unconsumed word
//   READY   consumer takes Q when VALID=1 and READY=1
//   OVR     sticky overrun, cleared only by R
//   BITCNT  bits collected in the current word, 0 when idle
module shift_reg_sipo_framed_rx
    import shift_reg_sipo_framed_rx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          C,
    input  logic                          R,
    input  logic                          SEN,
    input  logic                          SI,
    input  logic                          FSYNC,
    output logic [WIDTH-1:0]              Q,
    output logic                          VALID,
    input  logic                          READY,
    output logic                          OVR,
    output logic [clog2(WIDTH+1)-1:0]     BITCNT
);

    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;

    logic in_shift;
    logic start;      // SEN & FSYNC: begin a word, or resync one in progress
    logic shift_en;   // ordinary data bit inside a word
    logic last_bit;
    logic complete;   // this cycle's SI finishes the word
    logic drain;      // consumer takes the current Q this cycle
    logic accept;     // completed word may be written into the output slot

    assign in_shift = (state == ST_SHIFT);
    assign start    = SEN & FSYNC;
    assign shift_en = SEN & ~FSYNC & in_shift;
    assign last_bit = (BITCNT == CNT_LAST);
    // FSYNC on what would be the last bit is a resync, so it never completes.
    assign complete = shift_en & last_bit;
    assign drain    = VALID & READY;
    // Slot is writable if empty or being emptied on this very edge.
    assign accept   = complete & (~VALID | READY);

    shift_reg_sipo_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk      (C),
        .rst      (R),
        .en       (shift_en),
        .load     (start),
        .si       (SI),
        .sreg     (sreg),
        .sreg_nxt (sreg_nxt)
    );

    // Framing FSM and bit counter.
    always_ff @(posedge C) begin
        if (R) begin
            state  <= ST_IDLE;
            BITCNT <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SHIFT;
                        BITCNT <= CNT_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (start) begin
                        BITCNT <= CNT_ONE;
                    end else if (SEN) begin
                        if (last_bit) begin
                            // Each word needs its own FSYNC, so go back to idle.
                            state  <= ST_IDLE;
                            BITCNT <= '0;
                        end else begin
                            BITCNT <= BITCNT + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    BITCNT <= '0;
                end
            endcase
        end
    end

    // Output slot, handshake and overrun flag. The word captured is sreg_nxt,
    // i.e. the shifted value including the SI sampled this cycle.
    always_ff @(posedge C) begin
        if (R) begin
            Q     <= '0;
            VALID <= 1'b0;
            OVR   <= 1'b0;
        end else begin
            if (complete) begin
                if (accept) begin
                    Q     <= sreg_nxt;
                    VALID <= 1'b1;
                end else begin
                    OVR   <= 1'b1;
                end
            end else if (drain) begin
                VALID <= 1'b0;
            end
        end
    end

    // Q must not move underneath a consumer that has not yet taken it.
    a_q_stable : assert property (@(posedge C) disable iff (R)
        (VALID && !READY) |=> $stable(Q));

    // The counter never reaches WIDTH: the last bit returns it to zero.
    a_bitcnt_range : assert property (@(posedge C) disable iff (R)
        BITCNT < CW'(WIDTH));

    // The overrun flag only clears on reset.
    a_ovr_sticky : assert property (@(posedge C) disable iff (R)
        OVR |=> OVR);

endmodule

// File: tb/tb_shift_reg_sipo_framed_rx.sv
module tb_shift_reg_sipo_framed_rx;

    localparam int W  = 8;
    localparam int CW = 4;

    logic C = 1'b0;
    logic R = 1'b1;
    logic SEN = 1'b0;
    logic SI = 1'b0;
    logic FSYNC = 1'b0;
    logic READY = 1'b0;

    logic [W-1:0]  q_m, q_l;
    logic          valid_m, valid_l, ovr_m, ovr_l;
    logic [CW-1:0] bc_m, bc_l;

    always #5 C = ~C;

    shift_reg_sipo_framed_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .C(C), .R(R), .SEN(SEN), .SI(SI), .FSYNC(FSYNC),
        .Q(q_m), .VALID(valid_m), .READY(READY), .OVR(ovr_m), .BITCNT(bc_m)
    );

    shift_reg_sipo_framed_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .C(C), .R(R), .SEN(SEN), .SI(SI), .FSYNC(FSYNC),
        .Q(q_l), .VALID(valid_l), .READY(READY), .OVR(ovr_l), .BITCNT(bc_l)
    );

    int n_checks = 0;
    int n_errors = 0;
    int rises = 0;
    logic prev_valid = 1'b0;

    // Reference model: bits received so far in the current word, plus the output slot.
    bit           mbits[$];
    logic [W-1:0] m_q_m = '0;
    logic [W-1:0] m_q_l = '0;
    logic         m_valid = 1'b0;
    logic         m_ovr = 1'b0;

    typedef struct {
        logic          r, sen, si, fsync, ready;
        logic [W-1:0]  q;
        logic          valid, ovr;
        logic [CW-1:0] bc;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // i-th received bit lands at Q[W-1-i] for MSB-first, at Q[i] otherwise.
    function automatic logic [W-1:0] assemble(input bit msb, input bit b[$]);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb) w[W-1-i] = b[i];
            else     w[i]     = b[i];
        end
        return w;
    endfunction

    task automatic model_step();
        bit           done;
        logic [W-1:0] wm, wl;
        done = 1'b0;
        wm   = '0;
        wl   = '0;
        if (R) begin
            mbits.delete();
            m_q_m   = '0;
            m_q_l   = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        if (SEN) begin
            if (FSYNC) begin
                mbits.delete();
                mbits.push_back(SI);
            end else if (mbits.size() != 0) begin
                mbits.push_back(SI);
                if (mbits.size() == W) begin
                    done = 1'b1;
                    wm   = assemble(1'b1, mbits);
                    wl   = assemble(1'b0, mbits);
                    mbits.delete();
                end
            end
        end
        if (done) begin
            if (!m_valid || READY) begin
                m_q_m   = wm;
                m_q_l   = wl;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && READY) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: advance the model with the current inputs, let the edge pass,
    // then compare both DUTs against the model.
    task automatic cycle();
        model_step();
        @(posedge C);
        #1;
        if (valid_m && !prev_valid) rises++;
        prev_valid = valid_m;
        check("model_q_msb",   q_m,     m_q_m);
        check("model_q_lsb",   q_l,     m_q_l);
        check("model_valid_m", valid_m, m_valid);
        check("model_valid_l", valid_l, m_valid);
        check("model_ovr_m",   ovr_m,   m_ovr);
        check("model_ovr_l",   ovr_l,   m_ovr);
        check("model_bc_m",    bc_m,    mbits.size());
        check("model_bc_l",    bc_l,    mbits.size());
    endtask

    // Serial stream is w[W-1] first; READY is held low except optionally on the last bit.
    task automatic send_word(input logic [W-1:0] w, input logic rdy_last);
        for (int i = 0; i < W; i++) begin
            SEN   = 1'b1;
            SI    = w[W-1-i];
            FSYNC = (i == 0);
            READY = (i == W - 1) ? rdy_last : 1'b0;
            cycle();
        end
        SEN   = 1'b0;
        FSYNC = 1'b0;
        READY = 1'b0;
    endtask

    task automatic drain_slot();
        SEN   = 1'b0;
        FSYNC = 1'b0;
        READY = 1'b1;
        cycle();
        READY = 1'b0;
    endtask

    initial begin
        logic [W-1:0] pat;
        int lows, cycles, done_at, r0, g;

        // ---- Table: reset, idle, then 8'hA5 MSB-first with READY low, hold, drain.
        pat = 8'hA5;
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0});
        for (int i = 0; i < W; i++) begin
            tbl.push_back('{1'b0, 1'b1, pat[W-1-i], (i == 0), 1'b0,
                            (i == W - 1) ? 8'hA5 : 8'h00, (i == W - 1), 1'b0,
                            (i == W - 1) ? 4'd0 : CW'(i + 1)});
        end
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 4'd0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 4'd0});

        for (int i = 0; i < tbl.size(); i++) begin
            R     = tbl[i].r;
            SEN   = tbl[i].sen;
            SI    = tbl[i].si;
            FSYNC = tbl[i].fsync;
            READY = tbl[i].ready;
            cycle();
            check($sformatf("tbl%0d_q_m", i),   q_m,     tbl[i].q);
            check($sformatf("tbl%0d_q_l", i),   q_l,     tbl[i].q);
            check($sformatf("tbl%0d_valid", i), valid_m, tbl[i].valid);
            check($sformatf("tbl%0d_ovr", i),   ovr_m,   tbl[i].ovr);
            check($sformatf("tbl%0d_bitcnt", i), bc_m,   tbl[i].bc);
        end
        R = 1'b0; SEN = 1'b0; FSYNC = 1'b0; READY = 1'b0;

        // ---- LSB-first landing: A5 is a palindrome, 01 reverses to 80.
        send_word(8'hA5, 1'b0);
        check("t3_a5_lsb", q_l, 8'hA5);
        drain_slot();
        send_word(8'h01, 1'b0);
        check("t3_01_lsb", q_l, 8'h80);
        check("t3_01_msb", q_m, 8'h01);
        drain_slot();

        // ---- Overrun: second word into a held slot is dropped.
        send_word(8'h3C, 1'b0);
        check("t4_first_q", q_m, 8'h3C);
        check("t4_first_ovr", ovr_m, 1'b0);
        send_word(8'hC3, 1'b0);
        check("t4_held_q", q_m, 8'h3C);
        check("t4_ovr_set", ovr_m, 1'b1);
        check("t4_valid_held", valid_m, 1'b1);
        cycle();
        check("t4_ovr_sticky", ovr_m, 1'b1);
        drain_slot();
        check("t4_drained", valid_m, 1'b0);
        check("t4_ovr_after_drain", ovr_m, 1'b1);
        check("t4_q_kept", q_m, 8'h3C);
        R = 1'b1;
        cycle();
        R = 1'b0;
        check("t4_ovr_reset", ovr_m, 1'b0);

        // ---- Completion on the same edge the slot drains: replace, no overrun.
        send_word(8'h11, 1'b0);
        check("t5_first", q_m, 8'h11);
        send_word(8'h22, 1'b1);
        check("t5_q", q_m, 8'h22);
        check("t5_valid", valid_m, 1'b1);
        check("t5_ovr", ovr_m, 1'b0);
        drain_slot();

        // ---- Resync after 5 bits, then a full F0.
        r0 = rises;
        for (int i = 0; i < 5; i++) begin
            SEN = 1'b1; FSYNC = (i == 0); SI = 1'($urandom);
            cycle();
        end
        check("t6_partial_cnt", bc_m, 5);
        check("t6_partial_valid", valid_m, 1'b0);
        send_word(8'hF0, 1'b0);
        check("t6_q", q_m, 8'hF0);
        check("t6_single_rise", rises - r0, 1);
        check("t6_ovr", ovr_m, 1'b0);
        drain_slot();

        // ---- Reset mid-word discards the partial word.
        for (int i = 0; i < 4; i++) begin
            SEN = 1'b1; FSYNC = (i == 0); SI = 1'($urandom);
            cycle();
        end
        check("t6_pre_reset_cnt", bc_m, 4);
        SEN = 1'b0; FSYNC = 1'b0; R = 1'b1;
        cycle();
        R = 1'b0;
        check("t6_reset_cnt", bc_m, 0);
        check("t6_reset_valid", valid_m, 1'b0);
        SEN = 1'b1; SI = 1'b1;
        repeat (6) cycle();
        SEN = 1'b0;
        check("t6_no_word_after_reset", valid_m, 1'b0);
        check("t6_idle_cnt", bc_m, 0);

        // ---- SEN gaps stretch completion by exactly the number of low cycles.
        pat = 8'hA5;
        for (int t = 0; t < 4; t++) begin
            lows = 0; cycles = 0; done_at = -1;
            for (int i = 0; i < W; i++) begin
                if (i > 0) begin
                    g = $urandom_range(0, 3);
                    for (int k = 0; k < g; k++) begin
                        SEN = 1'b0; FSYNC = 1'($urandom); SI = 1'($urandom);
                        cycle();
                        cycles++; lows++;
                        if (valid_m && done_at < 0) done_at = cycles;
                    end
                end
                SEN = 1'b1; SI = pat[W-1-i]; FSYNC = (i == 0);
                cycle();
                cycles++;
                if (valid_m && done_at < 0) done_at = cycles;
            end
            SEN = 1'b0; FSYNC = 1'b0;
            check($sformatf("t7_%0d_q", t), q_m, 8'hA5);
            check($sformatf("t7_%0d_latency", t), done_at, W + lows);
            drain_slot();
        end

        // ---- Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            R     = ($urandom_range(0, 299) == 0);
            SEN   = ($urandom_range(0, 3) != 0);
            FSYNC = ($urandom_range(0, 11) == 0);
            SI    = 1'($urandom);
            READY = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
